hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-jump squashes and back-end stalls
// for multi-cycle divide and memory waits, with a watchdog on the divider.
module hazard_ctrl #(
   parameter int unsigned DIV_TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [4:0]  ex_rd_addr,
   input  logic        ex_mem_read,
   input  logic        ex_jmp,
   input  logic        ex_div_start,
   input  logic        div_done,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic        back_stall,
   output logic [1:0]  state,
   output logic        div_timeout,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count
);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StDivWait = 2'd1,
      StMemWait = 2'd2,
      StError   = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] div_tmr_q, div_tmr_d;
   logic        div_timeout_q, div_timeout_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] flush_count_q, flush_count_d;

   logic mem_wait, div_wait, load_use, back_stall_raw;

   assign mem_wait = mem_req & ~mem_ready;
   assign div_wait = ((state_q == StDivWait) & ~div_done) | ((state_q == StRun) & ex_div_start);
   assign load_use = ex_mem_read & (ex_rd_addr != 5'd0) &
                     ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) |
                      (id_rs2_used & (id_rs2_addr == ex_rd_addr)));
   assign back_stall_raw = mem_wait | div_wait | (state_q == StError);

   // Back-end stall outranks a jump, which in turn squashes any load-use hazard.
   always_comb begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      back_stall   = 1'b0;
      if (!rst) begin
         back_stall = back_stall_raw;
         if (back_stall_raw) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
         end else if (ex_jmp) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
         end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      div_tmr_d     = div_tmr_q;
      div_timeout_d = div_timeout_q;
      unique case (state_q)
         StRun: begin
            if (mem_wait) begin
               state_d = StMemWait;
            end else if (ex_div_start) begin
               state_d   = StDivWait;
               div_tmr_d = 32'd0;
            end
         end
         StDivWait: begin
            // A completion landing on the expiry cycle still counts as success.
            if (div_done) begin
               state_d = mem_wait ? StMemWait : StRun;
            end else if (div_tmr_q == DIV_TIMEOUT - 1) begin
               state_d       = StError;
               div_timeout_d = 1'b1;
            end else begin
               div_tmr_d = div_tmr_q + 32'd1;
            end
         end
         StMemWait: begin
            if (mem_ready) state_d = StRun;
         end
         StError: ;
         default: state_d = StRun;
      endcase
   end

   assign stall_cycles_d = (pc_stall && stall_cycles_q != 32'hFFFF_FFFF) ?
                           stall_cycles_q + 32'd1 : stall_cycles_q;
   assign flush_count_d  = flush_count_q + {15'd0, if_id_flush};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StRun;
         div_tmr_q      <= 32'd0;
         div_timeout_q  <= 1'b0;
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 16'd0;
      end else begin
         state_q        <= state_d;
         div_tmr_q      <= div_tmr_d;
         div_timeout_q  <= div_timeout_d;
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign state        = state_q;
   assign div_timeout  = div_timeout_q;
   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised and directed checks of hazard_ctrl against a cycle model of the hazard rules;
// two instances with different divider timeouts share the same stimulus.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_jmp;
   logic       ex_div_start, div_done, mem_req, mem_ready;

   logic        pcs [2];
   logic        ifst[2];
   logic        ifl [2];
   logic        bub [2];
   logic        bks [2];
   logic [1:0]  st  [2];
   logic        dto [2];
   logic [31:0] scy [2];
   logic [15:0] fcn [2];

   int checks = 0;
   int errors = 0;

   // Reference model state: mode 0 RUN, 1 DIV_WAIT, 2 MEM_WAIT, 3 ERROR
   int unsigned tmo [2] = '{40, 4};
   int          mode[2];
   int unsigned dcnt[2];
   bit          m_to[2];
   logic [31:0] m_sc[2];
   logic [15:0] m_fc[2];
   bit e_pc[2], e_ifs[2], e_fl[2], e_bub[2], e_bs[2];

   always #5 clk = ~clk;

   hazard_ctrl dut_a (
      .clk(clk), .rst(rst),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read), .ex_jmp(ex_jmp),
      .ex_div_start(ex_div_start), .div_done(div_done),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_stall(pcs[0]), .if_id_stall(ifst[0]), .if_id_flush(ifl[0]),
      .id_ex_bubble(bub[0]), .back_stall(bks[0]), .state(st[0]),
      .div_timeout(dto[0]), .stall_cycles(scy[0]), .flush_count(fcn[0])
   );

   hazard_ctrl #(.DIV_TIMEOUT(4)) dut_b (
      .clk(clk), .rst(rst),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read), .ex_jmp(ex_jmp),
      .ex_div_start(ex_div_start), .div_done(div_done),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_stall(pcs[1]), .if_id_stall(ifst[1]), .if_id_flush(ifl[1]),
      .id_ex_bubble(bub[1]), .back_stall(bks[1]), .state(st[1]),
      .div_timeout(dto[1]), .stall_cycles(scy[1]), .flush_count(fcn[1])
   );

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         mode[i] = 0; dcnt[i] = 0; m_to[i] = 1'b0; m_sc[i] = '0; m_fc[i] = '0;
      end
   endfunction

   function automatic void model_comb();
      bit mw, dw, lu, bs;
      mw = mem_req && !mem_ready;
      lu = ex_mem_read && ex_rd_addr != 0 &&
           ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
            (id_rs2_used && id_rs2_addr == ex_rd_addr));
      for (int i = 0; i < 2; i++) begin
         dw = (mode[i] == 1 && !div_done) || (mode[i] == 0 && ex_div_start);
         bs = mw || dw || mode[i] == 3;
         e_pc[i] = 0; e_ifs[i] = 0; e_fl[i] = 0; e_bub[i] = 0; e_bs[i] = 0;
         if (!rst) begin
            e_bs[i] = bs;
            if (bs) begin e_pc[i] = 1; e_ifs[i] = 1; end
            else if (ex_jmp) begin e_fl[i] = 1; e_bub[i] = 1; end
            else if (lu) begin e_pc[i] = 1; e_ifs[i] = 1; e_bub[i] = 1; end
         end
      end
   endfunction

   task automatic tick();
      bit mw;
      model_comb();
      mw = mem_req && !mem_ready;
      @(posedge clk);
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            if (e_pc[i] && m_sc[i] != 32'hFFFF_FFFF) m_sc[i] = m_sc[i] + 1;
            if (e_fl[i]) m_fc[i] = m_fc[i] + 1;
            case (mode[i])
               0: if (mw) mode[i] = 2;
                  else if (ex_div_start) begin mode[i] = 1; dcnt[i] = 0; end
               1: if (div_done) mode[i] = mw ? 2 : 0;
                  else begin
                     dcnt[i]++;
                     if (dcnt[i] == tmo[i]) begin mode[i] = 3; m_to[i] = 1; end
                  end
               2: if (mem_ready) mode[i] = 0;
               default: ;
            endcase
         end
      end
      #1;
   endtask

   task automatic set_idle();
      id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0;
      id_rs1_used = 0; id_rs2_used = 0; ex_mem_read = 0; ex_jmp = 0;
      ex_div_start = 0; div_done = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic rand_inputs();
      id_rs1_addr  = 5'($urandom_range(0, 7));
      id_rs2_addr  = 5'($urandom_range(0, 7));
      ex_rd_addr   = 5'($urandom_range(0, 7));
      id_rs1_used  = 1'($urandom_range(0, 1));
      id_rs2_used  = 1'($urandom_range(0, 1));
      ex_mem_read  = ($urandom_range(0, 99) < 40);
      ex_jmp       = ($urandom_range(0, 99) < 12);
      ex_div_start = ($urandom_range(0, 99) < 6);
      div_done     = ($urandom_range(0, 99) < 12);
      mem_req      = ($urandom_range(0, 99) < 30);
      mem_ready    = ($urandom_range(0, 99) < 60);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      tick();
      rst = 1'b0;
      set_idle();
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      ex_div_start = 1; tick();
      ex_div_start = 0; tick();
      rst = 1'b1;
      rand_inputs();
      #1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({pcs[i], ifst[i], ifl[i], bub[i], bks[i]} !== 5'b0) begin
            errors++;
            $display("FAIL rst_ctrl_zero[%0d]: got %b want 00000", i,
                     {pcs[i], ifst[i], ifl[i], bub[i], bks[i]});
         end
         checks++;
         if ({st[i], dto[i], scy[i], fcn[i]} !== 51'd0) begin
            errors++;
            $display("FAIL rst_regs[%0d]: state=%0d to=%b sc=%0d fc=%0d want all 0",
                     i, st[i], dto[i], scy[i], fcn[i]);
         end
      end
      tick();
      rst = 1'b0;
      set_idle();
      tick();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (st[i] !== 2'd0 || pcs[i] !== 1'b0 || bks[i] !== 1'b0 || scy[i] !== 32'd0) begin
            errors++;
            $display("FAIL post_rst[%0d]: state=%0d pc=%b bs=%b sc=%0d want 0 0 0 0",
                     i, st[i], pcs[i], bks[i], scy[i]);
         end
      end
   endtask

   task automatic test_load_use();
      do_reset();
      ex_mem_read = 1; ex_rd_addr = 5; id_rs1_addr = 5; id_rs1_used = 1;
      #1;
      checks++;
      if ({pcs[0], ifst[0], bub[0], ifl[0], bks[0]} !== 5'b11100) begin
         errors++;
         $display("FAIL load_use_ctrl: got %b want 11100",
                  {pcs[0], ifst[0], bub[0], ifl[0], bks[0]});
      end
      tick();
      ex_mem_read = 0;
      #1;
      checks++;
      if (pcs[0] !== 1'b0 || scy[0] !== 32'd1) begin
         errors++;
         $display("FAIL load_use_once: pc=%b sc=%0d want 0 1", pcs[0], scy[0]);
      end
      ex_mem_read = 1; ex_rd_addr = 0; id_rs1_addr = 0;
      #1;
      checks++;
      if ({pcs[0], ifst[0], bub[0]} !== 3'b000) begin
         errors++;
         $display("FAIL load_use_x0: got %b want 000", {pcs[0], ifst[0], bub[0]});
      end
      ex_rd_addr = 9; id_rs2_addr = 9; id_rs2_used = 1; id_rs1_addr = 3;
      #1;
      checks++;
      if ({pcs[0], ifst[0], bub[0]} !== 3'b111) begin
         errors++;
         $display("FAIL load_use_rs2: got %b want 111", {pcs[0], ifst[0], bub[0]});
      end
      set_idle();
      tick();
   endtask

   task automatic test_jump_load_use();
      do_reset();
      ex_mem_read = 1; ex_rd_addr = 5; id_rs1_addr = 5; id_rs1_used = 1; ex_jmp = 1;
      #1;
      checks++;
      if ({ifl[0], bub[0], pcs[0], ifst[0]} !== 4'b1100) begin
         errors++;
         $display("FAIL jmp_over_lu: got %b want 1100", {ifl[0], bub[0], pcs[0], ifst[0]});
      end
      tick();
      set_idle();
      #1;
      checks++;
      if (fcn[0] !== 16'd1 || scy[0] !== 32'd0) begin
         errors++;
         $display("FAIL jmp_counts: fc=%0d sc=%0d want 1 0", fcn[0], scy[0]);
      end
   endtask

   task automatic test_divide();
      int bad;
      do_reset();
      bad = 0;
      ex_div_start = 1;
      #1;
      if (bks[0] !== 1'b1) bad++;
      tick();
      ex_div_start = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (bks[0] !== 1'b1 || st[0] !== 2'd1) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL div_hold: %0d cycles without stall or DIV_WAIT, want 0", bad);
      end
      div_done = 1;
      #1;
      checks++;
      if (bks[0] !== 1'b0 || st[0] !== 2'd1) begin
         errors++;
         $display("FAIL div_done_release: bs=%b state=%0d want 0 1", bks[0], st[0]);
      end
      tick();
      div_done = 0;
      #1;
      checks++;
      if (st[0] !== 2'd0 || scy[0] !== 32'd11 || dto[0] !== 1'b0) begin
         errors++;
         $display("FAIL div_end: state=%0d sc=%0d to=%b want 0 11 0", st[0], scy[0], dto[0]);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      ex_div_start = 1; tick();
      ex_div_start = 0;
      repeat (3) tick();
      checks++;
      if (st[1] !== 2'd1 || dto[1] !== 1'b0) begin
         errors++;
         $display("FAIL to_not_yet: state=%0d to=%b want 1 0", st[1], dto[1]);
      end
      tick();
      checks++;
      if (st[1] !== 2'd3 || dto[1] !== 1'b1 || bks[1] !== 1'b1) begin
         errors++;
         $display("FAIL to_enter: state=%0d to=%b bs=%b want 3 1 1", st[1], dto[1], bks[1]);
      end
      div_done = 1; tick(); div_done = 0;
      repeat (4) tick();
      checks++;
      if (st[1] !== 2'd3 || dto[1] !== 1'b1 || st[0] !== 2'd0) begin
         errors++;
         $display("FAIL to_sticky: b.state=%0d b.to=%b a.state=%0d want 3 1 0",
                  st[1], dto[1], st[0]);
      end
      do_reset();
      checks++;
      if (st[1] !== 2'd0 || dto[1] !== 1'b0 || bks[1] !== 1'b0) begin
         errors++;
         $display("FAIL to_reset: state=%0d to=%b bs=%b want 0 0 0", st[1], dto[1], bks[1]);
      end
   endtask

   task automatic test_mem_wait_jump();
      int bad;
      do_reset();
      bad = 0;
      mem_req = 1; mem_ready = 0; ex_jmp = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         if ({bks[0], pcs[0], ifl[0]} !== 3'b110) bad++;
         tick();
      end
      checks++;
      if (bad != 0 || st[0] !== 2'd2) begin
         errors++;
         $display("FAIL mem_hold: bad=%0d state=%0d want 0 2", bad, st[0]);
      end
      mem_ready = 1;
      #1;
      checks++;
      if ({bks[0], pcs[0], ifl[0], bub[0]} !== 4'b0011) begin
         errors++;
         $display("FAIL mem_jmp_release: got %b want 0011",
                  {bks[0], pcs[0], ifl[0], bub[0]});
      end
      tick();
      set_idle();
      #1;
      checks++;
      if (scy[0] !== 32'd3 || fcn[0] !== 16'd1 || st[0] !== 2'd0) begin
         errors++;
         $display("FAIL mem_counts: sc=%0d fc=%0d state=%0d want 3 1 0", scy[0], fcn[0], st[0]);
      end
   endtask

   task automatic test_counter_bounds();
      do_reset();
      force dut_a.stall_cycles_q = 32'hFFFF_FFFE;
      force dut_a.flush_count_q  = 16'hFFFF;
      #1;
      release dut_a.stall_cycles_q;
      release dut_a.flush_count_q;
      m_sc[0] = 32'hFFFF_FFFE;
      m_fc[0] = 16'hFFFF;
      ex_mem_read = 1; ex_rd_addr = 7; id_rs1_addr = 7; id_rs1_used = 1;
      tick();
      checks++;
      if (scy[0] !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL sc_reach_max: got %h want ffffffff", scy[0]);
      end
      repeat (2) tick();
      checks++;
      if (scy[0] !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL sc_saturate: got %h want ffffffff", scy[0]);
      end
      ex_jmp = 1;
      tick();
      set_idle();
      #1;
      checks++;
      if (fcn[0] !== 16'h0000 || scy[0] !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL fc_wrap: fc=%h sc=%h want 0000 ffffffff", fcn[0], scy[0]);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         rand_inputs();
         #1;
         model_comb();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({pcs[i], ifst[i], ifl[i], bub[i], bks[i]} !==
                {e_pc[i], e_ifs[i], e_fl[i], e_bub[i], e_bs[i]}) begin
               errors++;
               $display("FAIL rnd_ctrl[%0d] cyc %0d: got %b want %b", i, c,
                        {pcs[i], ifst[i], ifl[i], bub[i], bks[i]},
                        {e_pc[i], e_ifs[i], e_fl[i], e_bub[i], e_bs[i]});
            end
            checks++;
            if (st[i] !== 2'(mode[i]) || dto[i] !== m_to[i]) begin
               errors++;
               $display("FAIL rnd_state[%0d] cyc %0d: state=%0d to=%b want %0d %b",
                        i, c, st[i], dto[i], mode[i], m_to[i]);
            end
            checks++;
            if (scy[i] !== m_sc[i] || fcn[i] !== m_fc[i]) begin
               errors++;
               $display("FAIL rnd_cnt[%0d] cyc %0d: sc=%0d fc=%0d want %0d %0d",
                        i, c, scy[i], fcn[i], m_sc[i], m_fc[i]);
            end
         end
         tick();
      end
   endtask

   initial begin
      set_idle();
      model_reset();
      tick();
      rst = 1'b0;
      #1;
      test_reset();
      test_load_use();
      test_jump_load_use();
      test_divide();
      test_timeout();
      test_mem_wait_jump();
      test_counter_bounds();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
